// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse/PWM generator.
// Optional build macro MULTI_PULSE_GEN_SYNC_START_EN adds a phase-align input.
package multi_pulse_gen_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int CH_W_MAX        = 4;
  localparam int PERIOD_DISABLED = 0;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
  } cfg_t;

endpackage

// File: rtl/multi_pulse_gen_if.sv
// Valid/ready configuration write port for multi_pulse_gen.
interface multi_pulse_gen_if
  import multi_pulse_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_high,
    output cfg_ready
  );

endinterface

// File: rtl/multi_pulse_gen_pulse_chan.sv
// One pulse/PWM channel: counter, live period/high, shadow registers and update handshake.
// With MULTI_PULSE_GEN_SYNC_START_EN defined, sync_start restarts the counter and applies any shadow.
module pulse_chan
  import multi_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef MULTI_PULSE_GEN_SYNC_START_EN
  input  logic             sync_start,
`endif
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             out,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
  logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
  logic             pending_q, pending_d;
  logic             out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             apply;

  always_comb begin
    cnt_d           = cnt_q;
    period_d        = period_q;
    high_d          = high_q;
    shadow_period_d = shadow_period_q;
    shadow_high_d   = shadow_high_q;
    pending_d       = pending_q;
    out_d           = out_q;
    wrap_d          = 1'b0;
    apply           = 1'b0;

    // A disabled channel picks up a pending shadow at once, independent of en.
    if (period_q == CNT_W'(PERIOD_DISABLED)) begin
      cnt_d = '0;
      out_d = 1'b0;
      apply = pending_q;
    end else if (en) begin
      out_d = (cnt_q < high_q);
      if (cnt_q == period_q) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        apply  = pending_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

`ifdef MULTI_PULSE_GEN_SYNC_START_EN
    if (sync_start) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
      apply  = pending_q;
    end
`endif

    if (apply) begin
      period_d  = shadow_period_q;
      high_d    = shadow_high_q;
      pending_d = 1'b0;
    end

    // The top only raises wr_en while pending is low, so this never races apply.
    if (wr_en) begin
      shadow_period_d = wr_period;
      shadow_high_d   = wr_high;
      pending_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q           <= '0;
      period_q        <= '0;
      high_q          <= '0;
      shadow_period_q <= '0;
      shadow_high_q   <= '0;
      pending_q       <= 1'b0;
      out_q           <= 1'b0;
      wrap_q          <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      period_q        <= period_d;
      high_q          <= high_d;
      shadow_period_q <= shadow_period_d;
      shadow_high_q   <= shadow_high_d;
      pending_q       <= pending_d;
      out_q           <= out_d;
      wrap_q          <= wrap_d;
    end
  end

  assign pending = pending_q;
  assign out     = out_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse/PWM generator with glitch-free runtime reconfiguration.
// Define MULTI_PULSE_GEN_SYNC_START_EN to add the sync_start phase-alignment input.
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef MULTI_PULSE_GEN_SYNC_START_EN
  input  logic                sync_start,
`endif
  multi_pulse_gen_if.slave    cfg,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] wrap
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wr_sel;
  logic                cfg_ready_d;

  // Channel numbers with no matching channel fall through as accepted-and-dropped.
  always_comb begin
    cfg_ready_d = 1'b1;
    wr_sel      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        cfg_ready_d = !pending[i];
        wr_sel[i]   = cfg.cfg_valid && !pending[i];
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pulse_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
`ifdef MULTI_PULSE_GEN_SYNC_START_EN
      .sync_start (sync_start),
`endif
      .wr_en      (wr_sel[g]),
      .wr_period  (cfg.cfg_period),
      .wr_high    (cfg.cfg_high),
      .pending    (pending[g]),
      .out        (out[g]),
      .wrap       (wrap[g])
    );
  end

endmodule
